cbfp1_exp_sched: RTL and testbench

Sequencer and exponent scheduler for the CBFP1 stage. It takes the per-cycle block-valid from the preceding butterfly and drives the stage enables `mag_en`, `min_en` and `valid_mod1` through the stage's 3-cycle pipeline. It also tracks each block's position within an FFT frame and buffers each block's shift amounts (`min_add`, `min_sub`) with its index. Downstream normalisation (CBFP2 / output rescale) pops them over a valid/ready handshake.

---
 rtl/cbfp1_pkg.sv | 17 +
 rtl/cbfp1_exp_fifo.sv | 56 +++++
 rtl/cbfp1_exp_sched.sv | 105 ++++++++++
 tb/tb_cbfp1_exp_sched.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbfp1_pkg.sv
// Shared CBFP1/CBFP2 definitions: exponent widths, frame geometry and the
// exponent buffer entry layout.
package cbfp1_pkg;

    localparam int LZC_WIDTH    = 5;
    localparam int FRAME_BLOCKS = 64;
    localparam int IDX_W        = $clog2(FRAME_BLOCKS);
    localparam int PIPE_LAT     = 3;

    typedef struct packed {
        logic [LZC_WIDTH-1:0] add;
        logic [LZC_WIDTH-1:0] sub;
        logic [IDX_W-1:0]     idx;
        logic                 last;
    } exp_entry_t;

endpackage

// File: rtl/cbfp1_exp_fifo.sv
// Synchronous first-word-fall-through FIFO for exponent entries; a push into a
// full buffer succeeds when a pop happens in the same cycle.
module cbfp1_exp_fifo
    import cbfp1_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter type entry_t = exp_entry_t
) (
    input  logic   clk,
    input  logic   rstn,
    input  logic   push,
    input  logic   pop,
    input  entry_t din,
    output entry_t dout,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is masked while empty so stale storage never shows after a reset.
    assign dout = empty ? entry_t'('0) : mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cbfp1_exp_sched.sv
// CBFP1 stage sequencer: drives the stage enables from the block-valid input,
// numbers blocks within a frame and buffers per-block shift amounts.
module cbfp1_exp_sched #(
    parameter int LZC_WIDTH    = 5,
    parameter int FRAME_BLOCKS = 64,
    parameter int FIFO_DEPTH   = 16,
    parameter int IDX_W        = $clog2(FRAME_BLOCKS)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 alert_cbfp,
    input  logic [LZC_WIDTH-1:0] min_add,
    input  logic [LZC_WIDTH-1:0] min_sub,
    output logic                 mag_en,
    output logic                 min_en,
    output logic                 valid_mod1,
    output logic [IDX_W-1:0]     blk_idx,
    output logic                 exp_valid,
    input  logic                 exp_ready,
    output logic [LZC_WIDTH-1:0] exp_add,
    output logic [LZC_WIDTH-1:0] exp_sub,
    output logic [IDX_W-1:0]     exp_idx,
    output logic                 exp_last,
    input  logic                 clr_ovf,
    output logic                 ovf
);

    import cbfp1_pkg::PIPE_LAT;

    typedef struct packed {
        logic [LZC_WIDTH-1:0] add;
        logic [LZC_WIDTH-1:0] sub;
        logic [IDX_W-1:0]     idx;
        logic                 last;
    } entry_t;

    logic [PIPE_LAT:1] v;
    logic [IDX_W-1:0]  idx_s1;
    logic [IDX_W-1:0]  idx_s2;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    entry_t            wr_entry;
    entry_t            head;

    assign mag_en     = alert_cbfp & rstn;
    assign min_en     = v[1];
    assign valid_mod1 = v[PIPE_LAT];

    // min-detect was registered on the v1 cycle, so its results are stable while v2 is high.
    assign push     = v[PIPE_LAT-1];
    assign wr_entry = '{add:  min_add,
                        sub:  min_sub,
                        idx:  idx_s2,
                        last: (idx_s2 == IDX_W'(FRAME_BLOCKS-1))};

    // exp_valid/exp_ready: an entry transfers on every cycle both are high;
    // exp_valid never depends on exp_ready and the head stays put until popped.
    assign exp_valid = !empty;
    assign pop       = exp_ready && !empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v       <= '0;
            idx_s1  <= '0;
            idx_s2  <= '0;
            blk_idx <= '0;
            ovf     <= 1'b0;
        end else begin
            v      <= {v[PIPE_LAT-1:1], alert_cbfp};
            idx_s1 <= blk_idx;
            idx_s2 <= idx_s1;
            if (alert_cbfp) begin
                blk_idx <= (blk_idx == IDX_W'(FRAME_BLOCKS-1)) ? '0 : blk_idx + IDX_W'(1);
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (push && full && !pop) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    cbfp1_exp_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .din   (wr_entry),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign exp_add  = head.add;
    assign exp_sub  = head.sub;
    assign exp_idx  = head.idx;
    assign exp_last = head.last;

endmodule

// File: tb/tb_cbfp1_exp_sched.sv
// Bench for cbfp1_exp_sched: directed scenarios plus random traffic against a
// history/queue reference model of the stage.
module tb_cbfp1_exp_sched;

    localparam int LZ  = 5;
    localparam int NB  = 64;
    localparam int DEP = 16;
    localparam int IW  = 6;

    typedef logic [2*LZ+IW:0] ent_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          alert_cbfp = 1'b0;
    logic          exp_ready = 1'b0;
    logic          clr_ovf = 1'b0;
    logic [LZ-1:0] min_add = '0;
    logic [LZ-1:0] min_sub = '0;
    logic          mag_en, min_en, valid_mod1, exp_valid, exp_last, ovf;
    logic [IW-1:0] blk_idx, exp_idx;
    logic [LZ-1:0] exp_add, exp_sub;
    ent_t          dut_head;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: alert history per cycle, expected exponent queue.
    ent_t          exp_q[$];
    logic          a_hist [8];
    logic [IW-1:0] i_hist [8];
    int            cyc;
    int            m_blk;
    logic          m_ovf;

    always #5 clk = ~clk;

    cbfp1_exp_sched dut (
        .clk        (clk),
        .rstn       (rstn),
        .alert_cbfp (alert_cbfp),
        .min_add    (min_add),
        .min_sub    (min_sub),
        .mag_en     (mag_en),
        .min_en     (min_en),
        .valid_mod1 (valid_mod1),
        .blk_idx    (blk_idx),
        .exp_valid  (exp_valid),
        .exp_ready  (exp_ready),
        .exp_add    (exp_add),
        .exp_sub    (exp_sub),
        .exp_idx    (exp_idx),
        .exp_last   (exp_last),
        .clr_ovf    (clr_ovf),
        .ovf        (ovf)
    );

    assign dut_head = {exp_add, exp_sub, exp_idx, exp_last};

    // Advance one clock and update the model with the inputs seen at that edge.
    task automatic cycle();
        logic [2:0] k;
        logic       pop;
        logic       push;
        logic       drop;
        ent_t       e;
        @(posedge clk);
        k    = 3'(cyc - 2);
        pop  = exp_ready && (exp_q.size() > 0);
        push = a_hist[k];
        e    = {min_add, min_sub, i_hist[k], (i_hist[k] == IW'(NB-1))};
        if (pop) void'(exp_q.pop_front());
        drop = push && (exp_q.size() == DEP);
        if (push && !drop) exp_q.push_back(e);
        if (drop) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
        a_hist[3'(cyc)] = alert_cbfp;
        i_hist[3'(cyc)] = IW'(m_blk);
        if (alert_cbfp) m_blk = (m_blk + 1) % NB;
        cyc++;
        @(negedge clk);
    endtask

    // Called at a falling edge; asserts reset asynchronously mid-cycle.
    task automatic do_reset();
        #2;
        rstn = 1'b0;
        alert_cbfp = 1'b1;
        #1;
        n_checks++;
        if ({mag_en, min_en, valid_mod1} !== 3'b000)
            $display("FAIL reset_ctrl: got %b expected 000", {mag_en, min_en, valid_mod1});
        else n_pass++;
        n_checks++;
        if ({exp_valid, dut_head} !== '0)
            $display("FAIL reset_fifo_out: got %h expected 0", {exp_valid, dut_head});
        else n_pass++;
        n_checks++;
        if ({ovf, blk_idx} !== '0)
            $display("FAIL reset_ovf_idx: got %h expected 0", {ovf, blk_idx});
        else n_pass++;
        exp_q.delete();
        foreach (a_hist[i]) begin
            a_hist[i] = 1'b0;
            i_hist[i] = '0;
        end
        m_ovf = 1'b0;
        m_blk = 0;
        cyc = 0;
        alert_cbfp = 1'b0;
        exp_ready = 1'b0;
        clr_ovf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if ({min_en, valid_mod1, exp_valid, ovf} !== 4'b0000)
            $display("FAIL reset_release: got %b expected 0000", {min_en, valid_mod1, exp_valid, ovf});
        else n_pass++;
        cycle();
    endtask

    task automatic test_single();
        ent_t e_ref;
        do_reset();
        alert_cbfp = 1'b1;
        #1;
        n_checks++;
        if (mag_en !== 1'b1) $display("FAIL single_mag_en: got %b expected 1", mag_en);
        else n_pass++;
        cycle();
        alert_cbfp = 1'b0;
        #1;
        n_checks++;
        if ({mag_en, min_en, valid_mod1} !== 3'b010)
            $display("FAIL single_t1: got %b expected 010", {mag_en, min_en, valid_mod1});
        else n_pass++;
        cycle();
        min_add = 5'd3;
        min_sub = 5'd7;
        #1;
        n_checks++;
        if ({min_en, valid_mod1, exp_valid} !== 3'b000)
            $display("FAIL single_t2: got %b expected 000", {min_en, valid_mod1, exp_valid});
        else n_pass++;
        cycle();
        min_add = '0;
        min_sub = '0;
        #1;
        e_ref = {5'd3, 5'd7, 6'd0, 1'b0};
        n_checks++;
        if ({valid_mod1, exp_valid} !== 2'b11)
            $display("FAIL single_t3_valid: got %b expected 11", {valid_mod1, exp_valid});
        else n_pass++;
        n_checks++;
        if (dut_head !== e_ref) $display("FAIL single_entry: got %h expected %h", dut_head, e_ref);
        else n_pass++;
        exp_ready = 1'b1;
        cycle();
        exp_ready = 1'b0;
        #1;
        n_checks++;
        if ({valid_mod1, exp_valid} !== 2'b00)
            $display("FAIL single_after_pop: got %b expected 00", {valid_mod1, exp_valid});
        else n_pass++;
    endtask

    task automatic test_full_frame();
        int nxt;
        nxt = 0;
        do_reset();
        exp_ready = 1'b1;
        for (int t = 0; t < 70; t++) begin
            alert_cbfp = (t < 65);
            min_add = LZ'($urandom);
            min_sub = LZ'($urandom);
            #1;
            if (t == 64) begin
                n_checks++;
                if (blk_idx !== '0) $display("FAIL frame_wrap: got %0d expected 0", blk_idx);
                else n_pass++;
            end
            n_checks++;
            if (exp_valid !== (exp_q.size() > 0))
                $display("FAIL frame_valid: got %b expected %b", exp_valid, exp_q.size() > 0);
            else n_pass++;
            if (exp_valid && exp_q.size() > 0) begin
                n_checks++;
                if (exp_idx !== IW'(nxt % NB)) $display("FAIL frame_idx: got %0d expected %0d", exp_idx, nxt % NB);
                else n_pass++;
                n_checks++;
                if (exp_last !== ((nxt % NB) == NB - 1))
                    $display("FAIL frame_last: got %b expected %b", exp_last, (nxt % NB) == NB - 1);
                else n_pass++;
                n_checks++;
                if (dut_head !== exp_q[0]) $display("FAIL frame_entry: got %h expected %h", dut_head, exp_q[0]);
                else n_pass++;
                nxt++;
            end
            cycle();
        end
        n_checks++;
        if (nxt !== 65) $display("FAIL frame_count: got %0d expected 65", nxt);
        else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int t = 0; t < 23; t++) begin
            alert_cbfp = (t < 20);
            min_add = LZ'($urandom);
            min_sub = LZ'($urandom);
            #1;
            cycle();
        end
        alert_cbfp = 1'b0;
        #1;
        n_checks++;
        if ({ovf, exp_valid} !== 2'b11) $display("FAIL ovf_set: got %b expected 11", {ovf, exp_valid});
        else n_pass++;
        n_checks++;
        if (exp_idx !== '0) $display("FAIL ovf_head: got %0d expected 0", exp_idx);
        else n_pass++;
        clr_ovf = 1'b1;
        cycle();
        clr_ovf = 1'b0;
        #1;
        n_checks++;
        if (ovf !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", ovf);
        else n_pass++;
        exp_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if ({exp_valid, exp_idx} !== {1'b1, IW'(k)})
                $display("FAIL ovf_drain: got v%b idx %0d expected v1 idx %0d", exp_valid, exp_idx, k);
            else n_pass++;
            n_checks++;
            if (exp_q.size() == 0 || dut_head !== exp_q[0])
                $display("FAIL ovf_entry: got %h expected model head (size %0d)", dut_head, exp_q.size());
            else n_pass++;
            cycle();
            #1;
        end
        n_checks++;
        if (exp_valid !== 1'b0) $display("FAIL ovf_empty: got %b expected 0", exp_valid);
        else n_pass++;
        exp_ready = 1'b0;
    endtask

    task automatic test_push_pop_full();
        do_reset();
        for (int t = 0; t < 19; t++) begin
            alert_cbfp = (t < 16);
            #1;
            cycle();
        end
        alert_cbfp = 1'b1;
        #1;
        cycle();
        alert_cbfp = 1'b0;
        #1;
        cycle();
        exp_ready = 1'b1;
        #1;
        n_checks++;
        if (exp_idx !== '0) $display("FAIL pp_head_before: got %0d expected 0", exp_idx);
        else n_pass++;
        cycle();
        exp_ready = 1'b0;
        #1;
        n_checks++;
        if ({ovf, exp_valid} !== 2'b01) $display("FAIL pp_ovf: got %b expected 01", {ovf, exp_valid});
        else n_pass++;
        n_checks++;
        if (exp_idx !== IW'(1)) $display("FAIL pp_head_after: got %0d expected 1", exp_idx);
        else n_pass++;
        exp_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if ({exp_valid, exp_idx} !== {1'b1, IW'(k + 1)})
                $display("FAIL pp_drain: got v%b idx %0d expected v1 idx %0d", exp_valid, exp_idx, k + 1);
            else n_pass++;
            cycle();
            #1;
        end
        n_checks++;
        if (exp_valid !== 1'b0) $display("FAIL pp_count: got %b expected 0", exp_valid);
        else n_pass++;
        exp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int t = 0; t < 10; t++) begin
            alert_cbfp = 1'b1;
            exp_ready = (t >= 3 && t <= 5);
            #1;
            cycle();
        end
        exp_ready = 1'b0;
        do_reset();
        alert_cbfp = 1'b1;
        min_add = 5'd9;
        #1;
        cycle();
        alert_cbfp = 1'b0;
        #1;
        cycle();
        #1;
        cycle();
        #1;
        n_checks++;
        if ({exp_valid, valid_mod1} !== 2'b11)
            $display("FAIL rmid_valid: got %b expected 11", {exp_valid, valid_mod1});
        else n_pass++;
        n_checks++;
        if (exp_idx !== '0) $display("FAIL rmid_idx: got %0d expected 0", exp_idx);
        else n_pass++;
        min_add = '0;
    endtask

    task automatic test_gapped();
        int   nxt;
        logic prev_min, prev_vm;
        nxt = 0;
        prev_min = 1'b0;
        prev_vm = 1'b0;
        do_reset();
        exp_ready = 1'b1;
        for (int t = 0; t < 24; t++) begin
            alert_cbfp = (t < 20) && (t % 2 == 0);
            #1;
            n_checks++;
            if ({min_en, valid_mod1} !== {a_hist[3'(cyc - 1)], a_hist[3'(cyc - 3)]})
                $display("FAIL gap_enables: got %b expected %b", {min_en, valid_mod1},
                         {a_hist[3'(cyc - 1)], a_hist[3'(cyc - 3)]});
            else n_pass++;
            n_checks++;
            if ((min_en && prev_min) || (valid_mod1 && prev_vm))
                $display("FAIL gap_isolated: got adjacent pulses at cycle %0d expected isolated", t);
            else n_pass++;
            prev_min = min_en;
            prev_vm = valid_mod1;
            if (exp_valid) begin
                n_checks++;
                if (exp_idx !== IW'(nxt)) $display("FAIL gap_idx: got %0d expected %0d", exp_idx, nxt);
                else n_pass++;
                nxt++;
            end
            cycle();
        end
        n_checks++;
        if (nxt !== 10) $display("FAIL gap_count: got %0d expected 10", nxt);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 400; t++) begin
            alert_cbfp = ($urandom_range(0, 3) != 0);
            exp_ready = (t < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr_ovf = ($urandom_range(0, 15) == 0);
            min_add = LZ'($urandom);
            min_sub = LZ'($urandom);
            #1;
            n_checks++;
            if ({mag_en, min_en, valid_mod1} !== {alert_cbfp, a_hist[3'(cyc - 1)], a_hist[3'(cyc - 3)]})
                $display("FAIL rnd_enables: got %b expected %b", {mag_en, min_en, valid_mod1},
                         {alert_cbfp, a_hist[3'(cyc - 1)], a_hist[3'(cyc - 3)]});
            else n_pass++;
            n_checks++;
            if (blk_idx !== IW'(m_blk)) $display("FAIL rnd_blk_idx: got %0d expected %0d", blk_idx, m_blk);
            else n_pass++;
            n_checks++;
            if (exp_valid !== (exp_q.size() > 0))
                $display("FAIL rnd_valid: got %b expected %b", exp_valid, exp_q.size() > 0);
            else n_pass++;
            if (exp_q.size() > 0) begin
                n_checks++;
                if (dut_head !== exp_q[0]) $display("FAIL rnd_head: got %h expected %h", dut_head, exp_q[0]);
                else n_pass++;
            end
            n_checks++;
            if (ovf !== m_ovf) $display("FAIL rnd_ovf: got %b expected %b", ovf, m_ovf);
            else n_pass++;
            cycle();
        end
        alert_cbfp = 1'b0;
        exp_ready = 1'b0;
        clr_ovf = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_full_frame();
        test_overflow();
        test_push_pop_full();
        test_reset_mid();
        test_gapped();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
